// File: rtl/xor_serial_scheduler_pkg.sv
// Shared definitions for the bit-serial XOR scheduler: FSM state encodings and
// the default operand width.
package xor_serial_scheduler_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/xor_serial_scheduler_xor.sv
// 1-bit XOR gate; the only XOR on the operand path, shared bit-serially by
// both requesters.
module xor_serial_scheduler_xor (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = a ^ b;

endmodule

// File: rtl/xor_serial_scheduler.sv
// Two-requester round-robin scheduler computing a XOR b one bit per cycle.
// Optional registered result parity port is enabled by XOR_SCHED_PARITY_EN.
module xor_serial_scheduler
   import xor_serial_scheduler_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             result_id
`ifdef XOR_SCHED_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-2:0] res_sr_q, res_sr_d;
   logic             rr_q, rr_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_id_q, result_id_d;
   logic             done_q, done_d;
`ifdef XOR_SCHED_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             xor_bit;
   logic [WIDTH-1:0] res_full;
   logic             sel;

   xor_serial_scheduler_xor u_xor (
      .a (a_sr_q[0]),
      .b (b_sr_q[0]),
      .y (xor_bit)
   );

   // The first WIDTH-1 result bits live in res_sr_q; the gate output completes the word.
   assign res_full = {xor_bit, res_sr_q};

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      res_sr_d    = res_sr_q;
      rr_d        = rr_q;
      id_d        = id_q;
      result_d    = result_q;
      result_id_d = result_id_q;
      done_d      = 1'b0;
`ifdef XOR_SCHED_PARITY_EN
      parity_d    = parity_q;
`endif
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      sel         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               // rr_q names the requester favoured on a tie; a lone request ignores it.
               sel = (req0 && req1) ? rr_q : req1;
               if (sel) begin
                  gnt1   = 1'b1;
                  a_sr_d = a1;
                  b_sr_d = b1;
               end else begin
                  gnt0   = 1'b1;
                  a_sr_d = a0;
                  b_sr_d = b0;
               end
               id_d    = sel;
               rr_d    = ~sel;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = res_full[WIDTH-1:1];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               result_d    = res_full;
               result_id_d = id_q;
`ifdef XOR_SCHED_PARITY_EN
               parity_d    = ^res_full;
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         res_sr_q    <= '0;
         rr_q        <= 1'b0;
         id_q        <= 1'b0;
         result_q    <= '0;
         result_id_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef XOR_SCHED_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         res_sr_q    <= res_sr_d;
         rr_q        <= rr_d;
         id_q        <= id_d;
         result_q    <= result_d;
         result_id_q <= result_id_d;
         done_q      <= done_d;
`ifdef XOR_SCHED_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign result    = result_q;
   assign result_id = result_id_q;
`ifdef XOR_SCHED_PARITY_EN
   assign parity    = parity_q;
`endif

endmodule
